aes_arbiter: RTL and testbench

Two-channel front-end controller for the iterative AES-128 core (`AES`, 128-bit, one round per clock). Each requester hands the arbiter a block, a key and a direction. The arbiter does the following:
- picks one requester round-robin;
- re-initialises the core when the direction changes;
- loads the key only when needed;
- pulses the core's data-ready input;
- waits for the result and returns it to the owning requester.

It sits directly in front of the single `AES` instance.

---
 rtl/aes_arb_pkg.sv | 31 +++
 rtl/aes_rr_arb.sv | 30 +++
 rtl/aes_arbiter.sv | 161 ++++++++++++++++
 tb/tb_aes_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and constants for the AES-128 front-end arbiter.
// Holds the FSM state enum, request and key-cache structs, the block width,
// the core busy time and the Ack-to-Vld latencies.
package aes_arb_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int AES_BUSY_CYCLES = 10;

  // Ack-to-Vld latency: cache hit, key load, direction change
  localparam int LAT_HIT = 12;
  localparam int LAT_KEY = 13;
  localparam int LAT_DIR = 14;

  typedef enum logic [2:0] {
    INIT, IDLE, ARST, KEY, DAT, WAIT, DONE
  } state_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0] din;
    logic [AES_BLK_W-1:0] key;
    logic                 dir;  // 0 encrypt, 1 decrypt
    logic                 kn;   // key differs from this channel's last request
  } req_t;

  typedef struct packed {
    logic vld;
    logic ch;
    logic dir;
  } kcache_t;

endpackage

// File: rtl/aes_rr_arb.sv
// aes_rr_arb: 2-way round-robin grant.
// Ports:
//   CLK, RST  clock, async active-high reset
//   req[1:0]  request vector
//   upd       a grant is being taken this cycle; advance the pointer
//   gnt       granted channel index (combinational, valid while |req)
// The pointer resets to 1 so channel 0 wins the first tie.
module aes_rr_arb
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt
);

  logic last;

  // On a tie pick the channel that was not served last
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      last <= 1'b1;
    else if (upd) last <= gnt;
  end

endmodule

// File: rtl/aes_arbiter.sv
// aes_arbiter: two-channel front end for a single iterative AES-128 core.
// Grants round-robin, resets the core on a direction change, loads the key
// when needed, pulses Drdy, waits for Dvld and hands the result back.
// Ports:
//   CLK, RST                        clock, async active-high reset
//   Req/Din/Key/EncDec/KeyNew[0|1]  per-channel request and payload
//   Ack[0|1], Vld[0|1], Dout        per-channel handshakes, shared result
//   AesDin/AesKey/AesDrdy/AesKrdy/AesEncDec/AesEN/AesRSTn  to the core
//   AesBSY/AesDvld/AesDout          from the core
// Build option: AES_ARB_KEYCACHE_EN skips the key load when the same
// channel reuses the same key in the same direction.
module aes_arbiter
  import aes_arb_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Req0,
  input  logic                 Req1,
  input  logic [AES_BLK_W-1:0] Din0,
  input  logic [AES_BLK_W-1:0] Din1,
  input  logic [AES_BLK_W-1:0] Key0,
  input  logic [AES_BLK_W-1:0] Key1,
  input  logic                 EncDec0,
  input  logic                 EncDec1,
  input  logic                 KeyNew0,
  input  logic                 KeyNew1,
  output logic                 Ack0,
  output logic                 Ack1,
  output logic                 Vld0,
  output logic                 Vld1,
  output logic [AES_BLK_W-1:0] Dout,
  output logic [AES_BLK_W-1:0] AesDin,
  output logic [AES_BLK_W-1:0] AesKey,
  output logic                 AesDrdy,
  output logic                 AesKrdy,
  output logic                 AesEncDec,
  output logic                 AesEN,
  output logic                 AesRSTn,
  input  logic                 AesBSY,
  input  logic                 AesDvld,
  input  logic [AES_BLK_W-1:0] AesDout
);

  state_t state;
  logic   own;      // channel owning the in-flight block
  logic   cur_dir;  // direction the core was last reset for
  logic   gnt;
  logic   take;
  logic   need_key;
  req_t   sel;

  // Completion is signalled by Dvld alone; BSY is not needed.
  logic unused_bsy;
  assign unused_bsy = AesBSY;

  assign sel  = gnt ? req_t'{Din1, Key1, EncDec1, KeyNew1}
                    : req_t'{Din0, Key0, EncDec0, KeyNew0};
  assign take = (state == IDLE) && (Req0 || Req1);

  // The direction register doubles as the core's EncDec line; during ARST
  // it already carries the new direction.
  assign AesEncDec = cur_dir;

  aes_rr_arb u_rr (
    .CLK (CLK),
    .RST (RST),
    .req ({Req1, Req0}),
    .upd (take),
    .gnt (gnt)
  );

`ifdef AES_ARB_KEYCACHE_EN
  kcache_t kc;
  assign need_key = !(kc.vld && kc.ch == gnt && kc.dir == sel.dir && !sel.kn);
`else
  logic unused_kn;
  assign unused_kn = KeyNew0 ^ KeyNew1;
  assign need_key  = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= INIT;
      own     <= 1'b0;
      cur_dir <= 1'b0;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      Vld0    <= 1'b0;
      Vld1    <= 1'b0;
      Dout    <= '0;
      AesDin  <= '0;
      AesKey  <= '0;
      AesDrdy <= 1'b0;
      AesKrdy <= 1'b0;
      AesEN   <= 1'b0;
      AesRSTn <= 1'b0;
`ifdef AES_ARB_KEYCACHE_EN
      kc      <= '0;
`endif
    end else begin
      // Pulsed outputs default low; core reset defaults released
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      Vld0    <= 1'b0;
      Vld1    <= 1'b0;
      AesDrdy <= 1'b0;
      AesKrdy <= 1'b0;
      AesRSTn <= 1'b1;
      case (state)
        INIT: begin
          AesEN <= 1'b1;
          state <= IDLE;
        end
        IDLE: if (take) begin
          own    <= gnt;
          AesDin <= sel.din;
          AesKey <= sel.key;
          Ack0   <= ~gnt;
          Ack1   <= gnt;
          // Outputs of the first action state are set here so they share
          // the cycle with Ack.
          if (sel.dir != cur_dir) begin
            state   <= ARST;
            AesRSTn <= 1'b0;
            cur_dir <= sel.dir;
`ifdef AES_ARB_KEYCACHE_EN
            kc.vld  <= 1'b0;
`endif
          end else if (need_key) begin
            state   <= KEY;
            AesKrdy <= 1'b1;
          end else begin
            state   <= DAT;
            AesDrdy <= 1'b1;
          end
        end
        ARST: begin
          state   <= KEY;
          AesKrdy <= 1'b1;
        end
        KEY: begin
          state   <= DAT;
          AesDrdy <= 1'b1;
`ifdef AES_ARB_KEYCACHE_EN
          kc      <= '{vld: 1'b1, ch: own, dir: cur_dir};
`endif
        end
        DAT: state <= WAIT;
        WAIT: if (AesDvld) begin
          Dout  <= AesDout;
          Vld0  <= ~own;
          Vld1  <= own;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter with a behavioural AES core that knows the
// FIPS-197 AES-128 vector pair and tracks its own loaded key and direction.
module tb_aes_arbiter;
  import aes_arb_pkg::*;

  localparam logic [127:0] K_ENC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_DEC = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BAD   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic CLK = 1'b0, RST = 1'b1;
  logic Req0 = 0, Req1 = 0, EncDec0 = 0, EncDec1 = 0, KeyNew0 = 0, KeyNew1 = 0;
  logic [127:0] Din0 = '0, Din1 = '0, Key0 = '0, Key1 = '0;
  logic Ack0, Ack1, Vld0, Vld1, AesDrdy, AesKrdy, AesEncDec, AesEN, AesRSTn;
  logic [127:0] Dout, AesDin, AesKey;
  logic AesBSY, AesDvld;
  logic [127:0] AesDout;

  int checks = 0, fails = 0;

  always #5 CLK = ~CLK;

  aes_arbiter dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1), .Din0(Din0), .Din1(Din1),
    .Key0(Key0), .Key1(Key1), .EncDec0(EncDec0), .EncDec1(EncDec1),
    .KeyNew0(KeyNew0), .KeyNew1(KeyNew1),
    .Ack0(Ack0), .Ack1(Ack1), .Vld0(Vld0), .Vld1(Vld1), .Dout(Dout),
    .AesDin(AesDin), .AesKey(AesKey), .AesDrdy(AesDrdy), .AesKrdy(AesKrdy),
    .AesEncDec(AesEncDec), .AesEN(AesEN), .AesRSTn(AesRSTn),
    .AesBSY(AesBSY), .AesDvld(AesDvld), .AesDout(AesDout)
  );

  // Behavioural core: Dvld 11 cycles after the Drdy cycle, using the key
  // captured on Krdy and the direction captured while RSTn was low.
  logic [127:0] mkey, mdin;
  logic         mdir, mkv;
  int           cnt;

  function automatic logic [127:0] core_f(logic [127:0] d, logic [127:0] k,
                                          logic dir, logic kv);
    if (kv && !dir && k == K_ENC && d == PT) return CT;
    if (kv &&  dir && k == K_DEC && d == CT) return PT;
    return BAD;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= 0; AesBSY <= 0; AesDvld <= 0; AesDout <= '0;
      mkv <= 0; mdir <= 0; mkey <= '0; mdin <= '0;
    end else begin
      AesDvld <= 0;
      if (!AesRSTn) begin
        mdir <= AesEncDec; mkv <= 0; cnt <= 0; AesBSY <= 0;
      end else begin
        if (AesKrdy) begin mkey <= AesKey; mkv <= 1; end
        if (AesDrdy && AesEN) begin
          mdin <= AesDin; cnt <= 1; AesBSY <= 1;
        end else if (cnt == AES_BUSY_CYCLES) begin
          cnt <= 0; AesBSY <= 0; AesDvld <= 1;
          AesDout <= core_f(mdin, mkey, mdir, mkv);
        end else if (cnt != 0) begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Krdy and Drdy must never be high together
  always @(negedge CLK) if (!RST) begin
    checks++;
    assert (!(AesKrdy && AesDrdy)) else begin
      fails++;
      $error("FAIL krdy_drdy_overlap: observed %b%b expected not both", AesKrdy, AesDrdy);
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, " ctl"}, {Ack0, Ack1, Vld0, Vld1, AesDrdy, AesKrdy, AesEncDec, AesEN, AesRSTn}, 0);
    chk({tag, " dout"}, Dout, 0);
    chk({tag, " aesdin"}, AesDin, 0);
    chk({tag, " aeskey"}, AesKey, 0);
  endtask

  // One request on one channel; checks Ack, latency and result.
  task automatic xfer(input int ch, input logic [127:0] din, input logic [127:0] key,
                      input logic ed, input logic kn, input int lat,
                      input logic [127:0] exp, input string tag,
                      output int krdy_n, output int rstn_n);
    int  n;
    bit  got;
    krdy_n = 0; rstn_n = 0;
    if (ch == 0) begin Din0 = din; Key0 = key; EncDec0 = ed; KeyNew0 = kn; Req0 = 1; end
    else         begin Din1 = din; Key1 = key; EncDec1 = ed; KeyNew1 = kn; Req1 = 1; end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      got = (ch == 0) ? Ack0 : Ack1;
    end
    chk({tag, " ack"}, got, 1);
    Req0 = 0; Req1 = 0;
    krdy_n += AesKrdy; rstn_n += !AesRSTn;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(negedge CLK); n++;
      krdy_n += AesKrdy; rstn_n += !AesRSTn;
      got = (ch == 0) ? Vld0 : Vld1;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " dout"}, Dout, exp);
    chk({tag, " other_vld"}, (ch == 0) ? Vld1 : Vld0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kr, rn, ng, nv;
    int g[3];
    int v[3];
    logic [127:0] vd[3];

    // Reset state
    #1 chk_rst("reset");
    repeat (2) @(negedge CLK);
    RST = 0;

    // Encrypt with key load
    xfer(0, PT, K_ENC, 0, 1, LAT_KEY, CT, "enc_key", kr, rn);
    chk("enc_key krdy", kr, 1);
    chk("enc_key rstn", rn, 0);

    // Encrypt again, same key
`ifdef AES_ARB_KEYCACHE_EN
    xfer(0, PT, K_ENC, 0, 0, LAT_HIT, CT, "enc_hit", kr, rn);
    chk("enc_hit krdy", kr, 0);
`else
    xfer(0, PT, K_ENC, 0, 0, LAT_KEY, CT, "enc_hit", kr, rn);
    chk("enc_hit krdy", kr, 1);
`endif

    // Decrypt on ch1: direction change
    xfer(1, CT, K_DEC, 1, 1, LAT_DIR, PT, "dec_dir", kr, rn);
    chk("dec_dir rstn", rn, 1);
    chk("dec_dir encdec", AesEncDec, 1);

    // Tie and alternation
    @(negedge CLK); RST = 1; @(negedge CLK); RST = 0;
    Din0 = PT; Key0 = K_ENC; EncDec0 = 0; KeyNew0 = 1;
    Din1 = CT; Key1 = K_DEC; EncDec1 = 1; KeyNew1 = 1;
    Req0 = 1; Req1 = 1;
    ng = 0; nv = 0;
    for (int i = 0; i < 120 && nv < 3; i++) begin
      @(negedge CLK);
      if ((Ack0 || Ack1) && ng < 3) begin g[ng] = Ack1 ? 1 : 0; ng++; end
      if (Vld0 || Vld1) begin v[nv] = Vld1 ? 1 : 0; vd[nv] = Dout; nv++; end
    end
    Req0 = 0; Req1 = 0;
    chk("tie ngrant", ng, 3);
    chk("tie nvld", nv, 3);
    chk("tie g0", g[0], 0);
    chk("tie g1", g[1], 1);
    chk("tie g2", g[2], 0);
    chk("tie v0", v[0], 0);
    chk("tie v1", v[1], 1);
    chk("tie v2", v[2], 0);
    chk("tie d0", vd[0], CT);
    chk("tie d1", vd[1], PT);
    chk("tie d2", vd[2], CT);
    repeat (3) @(negedge CLK);

    // Reset mid-operation during WAIT
    Din0 = PT; Key0 = K_ENC; EncDec0 = 0; KeyNew0 = 1; Req0 = 1;
    ng = 0;
    for (int i = 0; i < 50 && ng == 0; i++) begin
      @(negedge CLK);
      if (Ack0) ng = 1;
    end
    chk("mid ack", ng, 1);
    Req0 = 0;
    repeat (6) @(negedge CLK);
    RST = 1;
    #1 chk_rst("mid reset");
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (Vld0 || Vld1) nv++;
    end
    chk("mid no_vld", nv, 0);
    RST = 0;
    #1 chk("init rstn", {AesRSTn, AesEN}, 2'b00);
    @(negedge CLK);
    chk("post_init rstn", {AesRSTn, AesEN}, 2'b11);
    xfer(0, PT, K_ENC, 0, 1, LAT_KEY, CT, "after_rst", kr, rn);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
